// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
//  Shared Y86-64 constants for the pipeline control slice: instruction codes,
//  stage status codes, the "no register" id and the run-state encoding.
//  A small helper maps a writeback status onto the terminal run state.
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  // Instruction codes (icode field)
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Register id meaning "no register"; never takes part in a hazard compare
  localparam logic [3:0] RNONE = 4'hF;

  // Stage status codes
  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_HALTED = 3'd3,
    ST_FAULT  = 3'd4
  } run_state_e;

  // Terminal state implied by the writeback status; 'hold' when the status
  // does not end execution.
  function automatic run_state_e term_state(input logic [2:0] stat,
                                            input run_state_e hold);
    run_state_e res;
    res = hold;
    if (stat == S_HLT) begin
      res = ST_HALTED;
    end else if (stat == S_ADR || stat == S_INS) begin
      res = ST_FAULT;
    end
    return res;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_if
//  Bundle between the pipeline datapath (master) and the control unit (slave).
//  master drives: go, D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
//                 M_icode, m_stat, W_stat, W_icode
//  slave drives : F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
//                 run_state, halted, fault, final_stat
//  Handshake: there is no valid/ready pair. go is a one-cycle pulse that is
//  only looked at while the unit is IDLE; every other master signal is a
//  level sampled each cycle, and every slave output is valid every cycle.
// ---------------------------------------------------------------------------
interface pipe_ctrl_if;
  logic       go;
  logic [3:0] D_icode;
  logic [3:0] d_srcA;
  logic [3:0] d_srcB;
  logic [3:0] E_icode;
  logic [3:0] E_dstM;
  logic       e_Cnd;
  logic [3:0] M_icode;
  logic [2:0] m_stat;
  logic [2:0] W_stat;
  logic [3:0] W_icode;

  logic       F_stall;
  logic       D_stall;
  logic       D_bubble;
  logic       E_bubble;
  logic       M_bubble;
  logic       W_stall;
  logic [2:0] run_state;
  logic       halted;
  logic       fault;
  logic [2:0] final_stat;

  modport master (
    output go, D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
           M_icode, m_stat, W_stat, W_icode,
    input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
           run_state, halted, fault, final_stat
  );

  modport slave (
    input  go, D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
           M_icode, m_stat, W_stat, W_icode,
    output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
           run_state, halted, fault, final_stat
  );
endinterface

// File: rtl/pipe_ctrl_perf_ctr.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_perf_ctr
//  One saturating performance counter: counts up while enabled, sticks at
//  all-ones, synchronous clear.
//  Ports: clk, i_clr (sync clear, wins over enable), i_en, o_cnt[W-1:0]
// ---------------------------------------------------------------------------
module pipe_ctrl_perf_ctr #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
//  Y86-64 pipeline control unit. Detects load-use, ret and mispredicted-jump
//  hazards and drives per-stage stall/bubble, gated by a run-state FSM
//  (IDLE/RUN/DRAIN/HALTED/FAULT) that starts the pipe, lets it drain after a
//  memory-stage exception and freezes it once the exception reaches W.
//  Ports: clk, rst_n (sync, active low), pif (pipe_ctrl_if.slave)
//  Optional: PIPE_CTRL_PERF_EN adds perf_cycles, perf_retired,
//   perf_lu_stall, perf_mispred, perf_ret_bub (CNT_W bits each, saturating,
//   counting only in RUN/DRAIN).
//  Parameters: AUTO_START (leave IDLE on the first cycle after reset),
//   CNT_W (performance counter width).
// ---------------------------------------------------------------------------
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter bit AUTO_START = 1'b0,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_ctrl_if.slave        pif
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_cycles,
  output logic [CNT_W-1:0]  perf_retired,
  output logic [CNT_W-1:0]  perf_lu_stall,
  output logic [CNT_W-1:0]  perf_mispred,
  output logic [CNT_W-1:0]  perf_ret_bub
`endif
);

  run_state_e r_state;
  run_state_e w_next;
  logic       r_first;        // high on the first cycle after reset
  logic [2:0] r_final_stat;

  logic w_load_use;
  logic w_ret_pend;
  logic w_mispred;
  logic w_F_stall, w_D_stall, w_D_bubble, w_E_bubble, w_M_bubble, w_W_stall;
  logic w_active;

  // Hazard detection, purely from the stage registers
  assign w_load_use = ((pif.E_icode == I_MRMOVQ) || (pif.E_icode == I_POPQ)) &&
                      (pif.E_dstM != RNONE) &&
                      ((pif.E_dstM == pif.d_srcA) || (pif.E_dstM == pif.d_srcB));
  assign w_ret_pend = (pif.D_icode == I_RET) || (pif.E_icode == I_RET) ||
                      (pif.M_icode == I_RET);
  assign w_mispred  = (pif.E_icode == I_JXX) && !pif.e_Cnd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_first      <= 1'b1;
      r_final_stat <= S_AOK;
    end else begin
      r_state <= w_next;
      r_first <= 1'b0;
      // Capture the status that ended execution, once, on terminal entry
      if (((w_next == ST_HALTED) || (w_next == ST_FAULT)) &&
          (r_state != ST_HALTED) && (r_state != ST_FAULT)) begin
        r_final_stat <= pif.W_stat;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (pif.go || (AUTO_START && r_first)) begin
          w_next = ST_RUN;
        end
      end
      // An exception already in W skips DRAIN and ends execution directly
      ST_RUN:    w_next = term_state(pif.W_stat,
                                     (pif.m_stat != S_AOK) ? ST_DRAIN : ST_RUN);
      ST_DRAIN:  w_next = term_state(pif.W_stat, ST_DRAIN);
      ST_HALTED: w_next = ST_HALTED;
      ST_FAULT:  w_next = ST_FAULT;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_F_stall  = 1'b0;
    w_D_stall  = 1'b0;
    w_D_bubble = 1'b0;
    w_E_bubble = 1'b0;
    w_M_bubble = 1'b0;
    w_W_stall  = 1'b0;
    case (r_state)
      ST_RUN, ST_DRAIN: begin
        w_F_stall  = w_load_use | w_ret_pend;
        w_D_stall  = w_load_use;
        // A load-use stall holds D, so it overrides any bubble request there
        w_D_bubble = !w_load_use & (w_mispred | w_ret_pend);
        w_E_bubble = w_mispred | w_load_use;
        // While draining, keep younger instructions out of memory
        w_M_bubble = (r_state == ST_DRAIN);
      end
      ST_HALTED, ST_FAULT: begin
        w_F_stall  = 1'b1;
        w_D_stall  = 1'b1;
        w_E_bubble = 1'b1;
        w_M_bubble = 1'b1;
        w_W_stall  = 1'b1;
      end
      default: begin
        // IDLE (and any illegal encoding): fill the pipe with nops
        w_F_stall  = 1'b1;
        w_D_bubble = 1'b1;
        w_E_bubble = 1'b1;
        w_M_bubble = 1'b1;
      end
    endcase
  end

  assign w_active = (r_state == ST_RUN) || (r_state == ST_DRAIN);

  assign pif.F_stall    = w_F_stall;
  assign pif.D_stall    = w_D_stall;
  assign pif.D_bubble   = w_D_bubble;
  assign pif.E_bubble   = w_E_bubble;
  assign pif.M_bubble   = w_M_bubble;
  assign pif.W_stall    = w_W_stall;
  assign pif.run_state  = r_state;
  assign pif.halted     = (r_state == ST_HALTED);
  assign pif.fault      = (r_state == ST_FAULT);
  assign pif.final_stat = r_final_stat;

`ifdef PIPE_CTRL_PERF_EN
  logic w_clr;
  logic w_retire;
  logic w_ret_bub;

  assign w_clr     = !rst_n;
  assign w_retire  = (pif.W_stat == S_AOK) && (pif.W_icode != I_NOP) && !w_W_stall;
  assign w_ret_bub = !w_load_use & w_ret_pend;

  pipe_ctrl_perf_ctr #(.W(CNT_W)) u_cyc (
    .clk(clk), .i_clr(w_clr), .i_en(w_active), .o_cnt(perf_cycles));
  pipe_ctrl_perf_ctr #(.W(CNT_W)) u_ret (
    .clk(clk), .i_clr(w_clr), .i_en(w_active & w_retire), .o_cnt(perf_retired));
  pipe_ctrl_perf_ctr #(.W(CNT_W)) u_lu (
    .clk(clk), .i_clr(w_clr), .i_en(w_active & w_load_use), .o_cnt(perf_lu_stall));
  pipe_ctrl_perf_ctr #(.W(CNT_W)) u_mis (
    .clk(clk), .i_clr(w_clr), .i_en(w_active & w_mispred), .o_cnt(perf_mispred));
  pipe_ctrl_perf_ctr #(.W(CNT_W)) u_rbub (
    .clk(clk), .i_clr(w_clr), .i_en(w_active & w_ret_bub), .o_cnt(perf_ret_bub));
`else
  // W_icode and CNT_W only matter to the counters
  logic w_unused_perf;
  assign w_unused_perf = ^{pif.W_icode, w_active, {CNT_W{1'b0}}};
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl
//  Self-checking bench for pipe_ctrl. Inputs change on the falling edge,
//  outputs are sampled 1 ns later. Each scenario task holds a small table of
//  stimulus and expected outputs; expected vectors go into exp_q as the
//  stimulus is driven and are popped when the DUT output is sampled.
//  Output vector: {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall,
//                  run_state[2:0],halted,fault,final_stat[2:0]}
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam logic [5:0] HZ_NONE   = 6'b000000;
  localparam logic [5:0] HZ_IDLE   = 6'b101110;
  localparam logic [5:0] HZ_TERM   = 6'b110111;
  localparam logic [5:0] HZ_LU     = 6'b110100;
  localparam logic [5:0] HZ_MIS    = 6'b001100;
  localparam logic [5:0] HZ_RET    = 6'b101000;
  localparam logic [5:0] HZ_RETMIS = 6'b101100;
  localparam logic [5:0] HZ_DRAIN  = 6'b000010;
  localparam logic [5:0] HZ_LU_DR  = 6'b110110;

  localparam logic [2:0] Q_IDLE = 3'd0, Q_RUN = 3'd1, Q_DRAIN = 3'd2,
                         Q_HALT = 3'd3, Q_FAULT = 3'd4;

  typedef struct {
    logic       rst_n;
    logic       go;
    logic [3:0] d_icode, d_src_a, d_src_b, e_icode, e_dst_m, m_icode, w_icode;
    logic       e_cnd;
    logic [2:0] m_stat, w_stat;
  } stim_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_ctrl_if pif();

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_cycles, perf_retired, perf_lu_stall, perf_mispred, perf_ret_bub;
`endif

  pipe_ctrl #(.AUTO_START(1'b0), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pif   (pif)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_cycles   (perf_cycles),
    .perf_retired  (perf_retired),
    .perf_lu_stall (perf_lu_stall),
    .perf_mispred  (perf_mispred),
    .perf_ret_bub  (perf_ret_bub)
`endif
  );

  // scoreboard
  logic [13:0] exp_q[$];
  logic [13:0] got, ex;
  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [13:0] ev(input logic [5:0] hz, input logic [2:0] st,
                                     input logic [2:0] fs);
    return {hz, st, (st == Q_HALT), (st == Q_FAULT), fs};
  endfunction

  function automatic logic [13:0] outs();
    return {pif.F_stall, pif.D_stall, pif.D_bubble, pif.E_bubble, pif.M_bubble,
            pif.W_stall, pif.run_state, pif.halted, pif.fault, pif.final_stat};
  endfunction

  function automatic stim_t nop_stim();
    stim_t v;
    v.rst_n = 1'b1;   v.go = 1'b0;
    v.d_icode = I_NOP; v.d_src_a = RNONE; v.d_src_b = RNONE;
    v.e_icode = I_NOP; v.e_dst_m = RNONE; v.e_cnd = 1'b1;
    v.m_icode = I_NOP; v.m_stat = S_AOK;  v.w_stat = S_AOK; v.w_icode = I_NOP;
    return v;
  endfunction

  // driver
  task automatic apply(input stim_t v);
    rst_n       = v.rst_n;
    pif.go      = v.go;
    pif.D_icode = v.d_icode;
    pif.d_srcA  = v.d_src_a;
    pif.d_srcB  = v.d_src_b;
    pif.E_icode = v.e_icode;
    pif.E_dstM  = v.e_dst_m;
    pif.e_Cnd   = v.e_cnd;
    pif.M_icode = v.m_icode;
    pif.m_stat  = v.m_stat;
    pif.W_stat  = v.w_stat;
    pif.W_icode = v.w_icode;
  endtask

  task automatic test_reset();
    stim_t s[6];
    logic [13:0] e[6];
    for (int i = 0; i < 6; i++) s[i] = nop_stim();
    s[0].rst_n = 1'b0; s[0].go = 1'b1; e[0] = ev(HZ_IDLE, Q_IDLE, S_AOK);
    e[1] = ev(HZ_IDLE, Q_IDLE, S_AOK);                 // go during reset ignored
    s[2].go = 1'b1;    e[2] = ev(HZ_IDLE, Q_IDLE, S_AOK);
    e[3] = ev(HZ_NONE, Q_RUN, S_AOK);
    s[4].go = 1'b1;    e[4] = ev(HZ_NONE, Q_RUN, S_AOK);  // go ignored in RUN
    e[5] = ev(HZ_NONE, Q_RUN, S_AOK);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); apply(s[i]); exp_q.push_back(e[i]); #1;
      got = outs(); ex = exp_q.pop_front(); n_cmp++;
      if (got !== ex) begin
        n_fail++; $display("FAIL reset[%0d]: got %b expected %b", i, got, ex);
      end
    end
  endtask

  task automatic test_load_use();
    stim_t s[7];
    logic [13:0] e[7];
    for (int i = 0; i < 7; i++) begin s[i] = nop_stim(); e[i] = ev(HZ_NONE, Q_RUN, S_AOK); end
    s[0].e_icode = I_MRMOVQ; s[0].e_dst_m = 4'd3; s[0].d_src_a = 4'd3; e[0] = ev(HZ_LU, Q_RUN, S_AOK);
    s[1].e_icode = I_POPQ;   s[1].e_dst_m = 4'd5; s[1].d_src_b = 4'd5; e[1] = ev(HZ_LU, Q_RUN, S_AOK);
    s[2].e_icode = I_MRMOVQ; s[2].e_dst_m = RNONE; s[2].d_src_a = 4'd3;
    s[3].e_icode = I_MRMOVQ; s[3].e_dst_m = RNONE;          // RNONE vs RNONE
    s[4].e_icode = I_OPQ;    s[4].e_dst_m = 4'd3; s[4].d_src_a = 4'd3;
    s[5].e_icode = I_MRMOVQ; s[5].e_dst_m = 4'd3; s[5].d_src_a = 4'd2; s[5].d_src_b = 4'd4;
    s[6].e_icode = I_MRMOVQ; s[6].e_dst_m = 4'd3; s[6].d_src_a = 4'd3; s[6].d_icode = I_RET;
    e[6] = ev(HZ_LU, Q_RUN, S_AOK);                          // stall beats ret bubble
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); apply(s[i]); exp_q.push_back(e[i]); #1;
      got = outs(); ex = exp_q.pop_front(); n_cmp++;
      if (got !== ex) begin
        n_fail++; $display("FAIL load_use[%0d]: got %b expected %b", i, got, ex);
      end
    end
  endtask

  task automatic test_mispred();
    stim_t s[4];
    logic [13:0] e[4];
    for (int i = 0; i < 4; i++) begin s[i] = nop_stim(); e[i] = ev(HZ_NONE, Q_RUN, S_AOK); end
    s[0].e_icode = I_JXX; s[0].e_cnd = 1'b0; e[0] = ev(HZ_MIS, Q_RUN, S_AOK);
    s[1].e_icode = I_JXX; s[1].e_cnd = 1'b1;
    s[2].e_icode = I_OPQ; s[2].e_cnd = 1'b0;
    s[3].e_icode = I_JXX; s[3].e_cnd = 1'b0; s[3].d_icode = I_RET;
    e[3] = ev(HZ_RETMIS, Q_RUN, S_AOK);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); apply(s[i]); exp_q.push_back(e[i]); #1;
      got = outs(); ex = exp_q.pop_front(); n_cmp++;
      if (got !== ex) begin
        n_fail++; $display("FAIL mispred[%0d]: got %b expected %b", i, got, ex);
      end
    end
  endtask

  task automatic test_ret();
    stim_t s[4];
    logic [13:0] e[4];
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] rb0;
`endif
    for (int i = 0; i < 4; i++) begin s[i] = nop_stim(); e[i] = ev(HZ_RET, Q_RUN, S_AOK); end
    s[0].d_icode = I_RET; s[1].e_icode = I_RET; s[2].m_icode = I_RET;
    e[3] = ev(HZ_NONE, Q_RUN, S_AOK);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
`ifdef PIPE_CTRL_PERF_EN
      if (i == 0) rb0 = perf_ret_bub;
`endif
      apply(s[i]); exp_q.push_back(e[i]); #1;
      got = outs(); ex = exp_q.pop_front(); n_cmp++;
      if (got !== ex) begin
        n_fail++; $display("FAIL ret[%0d]: got %b expected %b", i, got, ex);
      end
    end
`ifdef PIPE_CTRL_PERF_EN
    n_cmp++;
    if (perf_ret_bub - rb0 !== 32'd3) begin
      n_fail++; $display("FAIL perf_ret_bub: got +%0d expected +3", perf_ret_bub - rb0);
    end
`endif
  endtask

  task automatic test_random();
    stim_t v;
    logic lu, rp, mp;
    logic [3:0] ics[6];
    ics[0] = I_NOP; ics[1] = I_RET; ics[2] = I_MRMOVQ;
    ics[3] = I_POPQ; ics[4] = I_JXX; ics[5] = I_OPQ;
    for (int i = 0; i < 40; i++) begin
      v = nop_stim();
      v.d_icode = ics[$urandom_range(0, 5)];
      v.e_icode = ics[$urandom_range(0, 5)];
      v.m_icode = (ics[$urandom_range(0, 5)] == I_RET && $urandom_range(0, 1) == 1) ? I_RET : I_NOP;
      v.d_src_a = ($urandom_range(0, 3) == 0) ? RNONE : 4'($urandom_range(2, 4));
      v.d_src_b = ($urandom_range(0, 3) == 0) ? RNONE : 4'($urandom_range(2, 4));
      v.e_dst_m = ($urandom_range(0, 3) == 0) ? RNONE : 4'($urandom_range(2, 4));
      v.e_cnd   = 1'($urandom_range(0, 1));
      lu = (v.e_icode == I_MRMOVQ || v.e_icode == I_POPQ) && (v.e_dst_m != RNONE) &&
           (v.e_dst_m == v.d_src_a || v.e_dst_m == v.d_src_b);
      rp = (v.d_icode == I_RET) || (v.e_icode == I_RET) || (v.m_icode == I_RET);
      mp = (v.e_icode == I_JXX) && !v.e_cnd;
      @(negedge clk); apply(v);
      exp_q.push_back(ev({lu | rp, lu, lu ? 1'b0 : (mp | rp), mp | lu, 1'b0, 1'b0},
                         Q_RUN, S_AOK));
      #1;
      got = outs(); ex = exp_q.pop_front(); n_cmp++;
      if (got !== ex) begin
        n_fail++; $display("FAIL random[%0d]: got %b expected %b", i, got, ex);
      end
    end
  endtask

  task automatic test_drain_fault();
    stim_t s[6];
    logic [13:0] e[6];
    for (int i = 0; i < 6; i++) s[i] = nop_stim();
    s[0].m_stat = S_ADR; e[0] = ev(HZ_NONE, Q_RUN, S_AOK);
    s[1].e_icode = I_MRMOVQ; s[1].e_dst_m = 4'd3; s[1].d_src_a = 4'd3;
    e[1] = ev(HZ_LU_DR, Q_DRAIN, S_AOK);
    s[2].w_stat = S_ADR; e[2] = ev(HZ_DRAIN, Q_DRAIN, S_AOK);
    s[3].go = 1'b1;      e[3] = ev(HZ_TERM, Q_FAULT, S_ADR);
    s[4].w_stat = S_HLT; s[4].m_stat = S_ADR; e[4] = ev(HZ_TERM, Q_FAULT, S_ADR);
    e[5] = ev(HZ_TERM, Q_FAULT, S_ADR);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); apply(s[i]); exp_q.push_back(e[i]); #1;
      got = outs(); ex = exp_q.pop_front(); n_cmp++;
      if (got !== ex) begin
        n_fail++; $display("FAIL drain_fault[%0d]: got %b expected %b", i, got, ex);
      end
    end
  endtask

  task automatic test_halt();
    stim_t s[6];
    logic [13:0] e[6];
    for (int i = 0; i < 6; i++) s[i] = nop_stim();
    s[0].rst_n = 1'b0; e[0] = ev(HZ_TERM, Q_FAULT, S_ADR);  // reset takes effect at the edge
    s[1].go = 1'b1;    e[1] = ev(HZ_IDLE, Q_IDLE, S_AOK);
    e[2] = ev(HZ_NONE, Q_RUN, S_AOK);
    s[3].w_stat = S_HLT; e[3] = ev(HZ_NONE, Q_RUN, S_AOK);
    e[4] = ev(HZ_TERM, Q_HALT, S_HLT);
    s[5].go = 1'b1;    e[5] = ev(HZ_TERM, Q_HALT, S_HLT);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); apply(s[i]); exp_q.push_back(e[i]); #1;
      got = outs(); ex = exp_q.pop_front(); n_cmp++;
      if (got !== ex) begin
        n_fail++; $display("FAIL halt[%0d]: got %b expected %b", i, got, ex);
      end
`ifdef PIPE_CTRL_PERF_EN
      if (i == 1) begin
        n_cmp++;
        if ({perf_cycles, perf_retired, perf_lu_stall, perf_mispred, perf_ret_bub} !== 160'd0) begin
          n_fail++; $display("FAIL perf_clear: cyc=%0d ret=%0d lu=%0d mis=%0d rb=%0d expected all 0",
                             perf_cycles, perf_retired, perf_lu_stall, perf_mispred, perf_ret_bub);
        end
      end
`endif
    end
  endtask

  task automatic test_reset_abort();
    stim_t s[9];
    logic [13:0] e[9];
    for (int i = 0; i < 9; i++) s[i] = nop_stim();
    s[0].rst_n = 1'b0; e[0] = ev(HZ_TERM, Q_HALT, S_HLT);
    s[1].go = 1'b1;    e[1] = ev(HZ_IDLE, Q_IDLE, S_AOK);
    s[2].m_stat = S_INS; e[2] = ev(HZ_NONE, Q_RUN, S_AOK);
    e[3] = ev(HZ_DRAIN, Q_DRAIN, S_AOK);
    s[4].rst_n = 1'b0; e[4] = ev(HZ_DRAIN, Q_DRAIN, S_AOK);
    s[5].w_stat = S_INS; e[5] = ev(HZ_IDLE, Q_IDLE, S_AOK);  // drain aborted
    s[6].go = 1'b1;    e[6] = ev(HZ_IDLE, Q_IDLE, S_AOK);
    s[7].m_stat = S_ADR; s[7].w_stat = S_INS; e[7] = ev(HZ_NONE, Q_RUN, S_AOK);
    e[8] = ev(HZ_TERM, Q_FAULT, S_INS);                      // W exception skips DRAIN
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); apply(s[i]); exp_q.push_back(e[i]); #1;
      got = outs(); ex = exp_q.pop_front(); n_cmp++;
      if (got !== ex) begin
        n_fail++; $display("FAIL reset_abort[%0d]: got %b expected %b", i, got, ex);
      end
    end
  endtask

  initial begin
    apply(nop_stim());
    rst_n = 1'b0;
    @(posedge clk);
    test_reset();
    test_load_use();
    test_mispred();
    test_ret();
    test_random();
    test_drain_fault();
    test_halt();
    test_reset_abort();
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard: %0d expected entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
